// File: rtl/alu_datapath_pkg.sv
// Shared widths, opcode constants and ALU operation codes for the ALU datapath.
package alu_datapath_pkg;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 7;

  // Major opcodes, instr[15:13]
  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_ANDI  = 3'b010;
  localparam logic [2:0] OP_ORI   = 3'b011;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_JMP   = 3'b111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOR = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_code_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: eight operations plus a carry/borrow flag.
module alu_core
  import alu_datapath_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_code_e         i_code,
  output logic [DATA_W-1:0] o_out,
  output logic              o_carry
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // Widen by one bit so the top bit is the carry-out (ADD) or borrow (SUB).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // Select the operation result; carry is only meaningful for ADD and SUB.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_out   = w_sum[DATA_W-1:0];
    o_carry = 1'b0;
    unique case (i_code)
      ALU_ADD: begin
        o_out   = w_sum[DATA_W-1:0];
        o_carry = w_sum[DATA_W];
      end
      ALU_SUB: begin
        o_out   = w_diff[DATA_W-1:0];
        o_carry = w_diff[DATA_W];
      end
      ALU_AND: o_out = i_a & i_b;
      ALU_OR:  o_out = i_a | i_b;
      ALU_XOR: o_out = i_a ^ i_b;
      ALU_NOR: o_out = ~(i_a | i_b);
      ALU_SLL: o_out = i_a << i_b[3:0];
      ALU_SRL: o_out = i_a >> i_b[3:0];
      default: o_out = w_sum[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/alu_datapath.sv
// Single-cycle ALU stage: instruction decode, operand-B mux, ALU and output registers.
module alu_datapath #(
  parameter int DATA_W = alu_datapath_pkg::DATA_W,
  parameter int IMM_W  = alu_datapath_pkg::IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] read1,
  input  logic [DATA_W-1:0] read2,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic [2:0]        alu_code,
  output logic              use_imm,
  output logic              illegal
);

  import alu_datapath_pkg::*;

  logic [2:0]        w_opcode;
  logic [3:0]        w_func;
  alu_code_e         w_code;
  logic              w_use_imm;
  logic              w_illegal;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu_out;
  logic              w_alu_carry;
  logic              w_unused_regs;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_carry;
  logic              r_zero;
  alu_code_e         r_alu_code;
  logic              r_use_imm;
  logic              r_illegal;

  assign w_opcode  = instr[15:13];
  assign w_func    = instr[3:0];
  // Register specifiers are consumed by the register file upstream, not here.
  assign w_unused_regs = ^instr[12:7];
  assign w_imm_ext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  assign w_b       = w_use_imm ? w_imm_ext : read2;

  // Decode opcode/func into an ALU operation and operand-B select.
  always_comb begin
    w_code    = ALU_ADD;
    w_use_imm = 1'b1;
    w_illegal = 1'b0;
    unique case (w_opcode)
      OP_RTYPE: begin
        w_use_imm = 1'b0;
        if (w_func[3]) begin
          w_code    = ALU_ADD;
          w_illegal = 1'b1;
        end else begin
          w_code = alu_code_e'(w_func[2:0]);
        end
      end
      OP_ADDI, OP_LW, OP_SW, OP_JMP: w_code = ALU_ADD;
      OP_ANDI: w_code = ALU_AND;
      OP_ORI:  w_code = ALU_OR;
      OP_BEQ: begin
        w_code    = ALU_SUB;
        w_use_imm = 1'b0;
      end
      default: w_code = ALU_ADD;
    endcase
  end

  alu_core u_alu (
    .i_a     (read1),
    .i_b     (w_b),
    .i_code  (w_code),
    .o_out   (w_alu_out),
    .o_carry (w_alu_carry)
  );

  // Output registers: capture on in_valid, otherwise hold; out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_alu_code  <= ALU_ADD;
      r_use_imm   <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result   <= w_alu_out;
        r_carry    <= w_alu_carry;
        r_zero     <= (w_alu_out == '0);
        r_alu_code <= w_code;
        r_use_imm  <= w_use_imm;
        r_illegal  <= w_illegal;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign alu_code  = r_alu_code;
  assign use_imm   = r_use_imm;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: directed vector table, reset and hold
// sequences, then randomized traffic against a behavioural model.
module tb_alu_datapath;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic [2:0]  code;
    logic        ui;
    logic        il;
  } vec_t;

  typedef struct {
    logic        v;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic [2:0]  code;
    logic        ui;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] read1 = '0;
  logic [15:0] read2 = '0;
  logic        out_valid;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic [2:0]  alu_code;
  logic        use_imm;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  exp_t held;

  always #5 clk = ~clk;

  alu_datapath dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .instr     (instr),
    .read1     (read1),
    .read2     (read2),
    .out_valid (out_valid),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .alu_code  (alu_code),
    .use_imm   (use_imm),
    .illegal   (illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e.v));
    check({tag, ".result"},    32'(result),    32'(e.res));
    check({tag, ".carry"},     32'(carry),     32'(e.c));
    check({tag, ".zero"},      32'(zero),      32'(e.z));
    check({tag, ".alu_code"},  32'(alu_code),  32'(e.code));
    check({tag, ".use_imm"},   32'(use_imm),   32'(e.ui));
    check({tag, ".illegal"},   32'(illegal),   32'(e.il));
  endtask

  // Behavioural model: opcode table plus integer arithmetic modulo 2^16.
  function automatic exp_t model(input logic [15:0] ins, input logic [15:0] a16,
                                 input logic [15:0] b16);
    exp_t e;
    int op_code [8];
    int op, fn, imm, a, b, code, s, r;
    bit sel_imm, il, c;
    op_code = '{0, 0, 2, 3, 0, 0, 1, 0};
    op  = int'(ins[15:13]);
    fn  = int'(ins[3:0]);
    imm = int'(ins[6:0]);
    a   = int'(a16);
    sel_imm = !(op == 0 || op == 6);
    b = sel_imm ? ((imm >= 64) ? imm - 128 + 65536 : imm) : int'(b16);
    il = 0;
    code = op_code[op];
    if (op == 0) begin
      code = (fn < 8) ? fn : 0;
      il   = (fn >= 8);
    end
    c = 0;
    case (code)
      0: begin s = a + b; r = s % 65536; c = (s > 65535); end
      1: begin r = (a - b + 65536) % 65536; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~(a | b)) & 65535;
      6: r = (a << (b % 16)) & 65535;
      default: r = a >> (b % 16);
    endcase
    e.v = 1'b1; e.res = 16'(r); e.c = c; e.z = (r == 0);
    e.code = 3'(code); e.ui = sel_imm; e.il = il;
    return e;
  endfunction

  // Drive one cycle of input at the falling edge; outputs settle after the rising edge.
  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    in_valid = v; instr = ins; read1 = a; read2 = b;
    @(posedge clk);
    #1;
    if (v) held = model(ins, a, b);
    held.v = v;
  endtask

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, zero_e;
    logic [15:0] pool [4];
    vecs = '{
      '{16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 3'd0, 0, 0},  // R ADD wrap
      '{16'hC000, 16'h0003, 16'h0005, 16'hFFFE, 1, 0, 3'd1, 0, 0},  // BEQ borrow
      '{16'h207F, 16'h0010, 16'h1234, 16'h000F, 1, 0, 3'd0, 1, 0},  // ADDI -1
      '{16'h0006, 16'h0001, 16'h0013, 16'h0008, 0, 0, 3'd6, 0, 0},  // SLL by 3
      '{16'h0009, 16'h0005, 16'h0007, 16'h000C, 0, 0, 3'd0, 0, 1},  // illegal func
      '{16'h4040, 16'h1234, 16'h0000, 16'h1200, 0, 0, 3'd2, 1, 0},  // ANDI 0xFFC0
      '{16'h0001, 16'h0005, 16'h0005, 16'h0000, 0, 1, 3'd1, 0, 0},  // SUB equal
      '{16'h0007, 16'h8000, 16'h000F, 16'h0001, 0, 0, 3'd7, 0, 0},  // SRL logical
      '{16'h0005, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 3'd5, 0, 0},  // NOR
      '{16'h8005, 16'hFFFF, 16'h0000, 16'h0004, 1, 0, 3'd0, 1, 0},  // LW wrap
      '{16'hE03F, 16'h0000, 16'hFFFF, 16'h003F, 0, 0, 3'd0, 1, 0},  // JMP
      '{16'h0004, 16'hAAAA, 16'h5555, 16'hFFFF, 0, 0, 3'd4, 0, 0},  // XOR
      '{16'hA040, 16'h0040, 16'h0000, 16'h0000, 1, 1, 3'd0, 1, 0},  // SW to zero
      '{16'h0003, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 3'd3, 0, 0}   // OR
    };
    zero_e = '{0, 16'h0, 0, 0, 3'd0, 0, 0};
    held = zero_e;

    // Reset state, asynchronously applied
    #1;
    check_all("reset", zero_e);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].instr, vecs[i].r1, vecs[i].r2);
      e = '{1'b1, vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].code, vecs[i].ui, vecs[i].il};
      check_all($sformatf("vec%0d", i), e);
    end

    // ORI result then three idle cycles: outputs hold, out_valid drops
    drive(1'b1, 16'h6000, 16'h00F0, 16'hFFFF);
    e = '{1'b1, 16'h00F0, 0, 0, 3'd3, 1, 0};
    check_all("ori", e);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'h0000, 16'h0000, 16'h0000);
      e.v = 1'b0;
      check_all($sformatf("hold%0d", k), e);
    end

    // Reset mid-stream with in_valid high: outputs clear without a clock edge
    drive(1'b1, 16'h0001, 16'h0009, 16'h0002);
    check("pre_rst.result", 32'(result), 32'h0007);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", zero_e);
    @(posedge clk);
    #1;
    check_all("rst_edge", zero_e);
    @(negedge clk);
    rst_n = 1'b1;
    held = zero_e;
    drive(1'b1, 16'h0003, 16'h1200, 16'h0034);
    e = '{1'b1, 16'h1234, 0, 0, 3'd3, 0, 0};
    check_all("post_rst", e);

    // Randomized traffic against the model, edge-biased operands
    pool = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};
    for (int n = 0; n < 300; n++) begin
      logic [15:0] ins, a, b;
      logic v;
      ins = 16'($urandom);
      a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : 16'($urandom);
      v = ($urandom_range(0, 3) != 0);
      drive(v, ins, a, b);
      check_all($sformatf("rnd%0d", n), held);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
